mode_operand_router: RTL and testbench

- Registered, flow-controlled successor to the combinational mode input selector. Routes two of four W-bit operand lanes to out1/out2 according to a 3-bit mode.
- The mode is loaded through a write strobe and applied only once the output stage has drained, so no beat is ever emitted under a mode it was not selected with.
- Sits between the operand sources and the arithmetic datapath.
- Adds valid/ready handshakes on both sides, a mode-switch FSM, an illegal-mode sticky flag and a per-mode beat counter.

---
 rtl/mode_operand_router.sv | 105 ++++++++++
 tb/tb_mode_operand_router.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_operand_router.sv
// Registered operand router: routes two of four lanes to out1/out2 by a 3-bit mode,
// with valid/ready on both sides and a drain-before-switch mode FSM.
module mode_operand_router #(
    parameter int         W        = 8,
    parameter int         CW       = 8,
    parameter logic [2:0] RST_MODE = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode_in,
    input  logic             mode_wr,
    output logic             mode_busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*W-1:0]   in_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out1,
    output logic [W-1:0]     out2,
    output logic [2:0]       out_mode,
    output logic [CW-1:0]    beat_cnt,
    output logic             mode_err
);

    localparam logic RUN   = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic         state;
    logic [2:0]   cur_mode;
    logic [2:0]   pending;
    logic [W-1:0] route1;
    logic [W-1:0] route2;
    logic         accept;
    logic         stage_free;

    assign stage_free = !out_valid || out_ready;
    assign in_ready   = (state == RUN) && stage_free;
    assign accept     = in_valid && in_ready;
    assign mode_busy  = (state == DRAIN);

    always_comb begin
        // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
        route1 = '0;
        route2 = '0;
        case (cur_mode)
            3'd0, 3'd1, 3'd4, 3'd5: route1 = in_bus[2*W +: W];
            3'd2: begin
                route1 = in_bus[1*W +: W];
                route2 = in_bus[0*W +: W];
            end
            3'd3: begin
                route1 = in_bus[2*W +: W];
                route2 = in_bus[3*W +: W];
            end
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cur_mode  <= RST_MODE;
            pending   <= '0;
            out_valid <= 1'b0;
            out1      <= '0;
            out2      <= '0;
            out_mode  <= '0;
            beat_cnt  <= '0;
            mode_err  <= 1'b0;
        end else begin
            if (accept) begin
                out1      <= route1;
                out2      <= route2;
                out_mode  <= cur_mode;
                out_valid <= 1'b1;
                if (beat_cnt != '1)
                    beat_cnt <= beat_cnt + CW'(1);
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (mode_wr) begin
                        pending <= mode_in;
                        state   <= DRAIN;
                    end
                end
                default: begin
                    // No accept can happen in DRAIN, so clearing the counter here cannot race an increment.
                    if (stage_free) begin
                        cur_mode  <= pending;
                        beat_cnt  <= '0;
                        out_valid <= 1'b0;
                        state     <= RUN;
                        if (pending[2:1] == 2'b11)
                            mode_err <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mode_operand_router.sv
// Bench for mode_operand_router: mode table vectors, a scoreboard on the output
// handshake, and hand-written drain/reset/saturation sequences.
module tb_mode_operand_router;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] o1;
        logic [7:0] o2;
        logic [2:0] m;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode_in;
    logic        mode_wr;
    logic        in_valid;
    logic [31:0] in_bus;
    logic        out_ready;

    logic        mode_busy, in_ready, out_valid, mode_err;
    logic [7:0]  out1, out2, beat_cnt;
    logic [2:0]  out_mode;

    logic        mode_busy3, in_ready3, out_valid3, mode_err3;
    logic [7:0]  out13, out23;
    logic [2:0]  out_mode3;
    logic [2:0]  beat_cnt3;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [2:0]  tb_mode = 3'd0;
    beat_t       sb[$];
    vec_t        vecs[8];

    always #5 clk = ~clk;

    mode_operand_router #(.W(8), .CW(8), .RST_MODE(3'b000)) dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_wr(mode_wr), .mode_busy(mode_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_bus(in_bus),
        .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .out2(out2),
        .out_mode(out_mode), .beat_cnt(beat_cnt), .mode_err(mode_err)
    );

    // Same stimulus, 3-bit counter to exercise saturation.
    mode_operand_router #(.W(8), .CW(3), .RST_MODE(3'b000)) dut3 (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_wr(mode_wr), .mode_busy(mode_busy3),
        .in_valid(in_valid), .in_ready(in_ready3), .in_bus(in_bus),
        .out_valid(out_valid3), .out_ready(out_ready), .out1(out13), .out2(out23),
        .out_mode(out_mode3), .beat_cnt(beat_cnt3), .mode_err(mode_err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t route(input logic [2:0] m, input logic [31:0] bus);
        beat_t b;
        b.o1 = 8'h00;
        b.o2 = 8'h00;
        b.m  = m;
        if (m == 3'd2) begin
            b.o1 = bus[15:8];
            b.o2 = bus[7:0];
        end else if (m == 3'd3) begin
            b.o1 = bus[23:16];
            b.o2 = bus[31:24];
        end else if (m != 3'd6 && m != 3'd7) begin
            b.o1 = bus[23:16];
        end
        return b;
    endfunction

    // Scoreboard: compare the beat leaving the stage, then record the beat entering it.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_beat", {out1, out2, 5'd0, out_mode}, 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    check("sb_beat", {out1, out2, 5'd0, out_mode}, {e.o1, e.o2, 5'd0, e.m});
                end
            end
            if (in_valid && in_ready)
                sb.push_back(route(tb_mode, in_bus));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [2:0] m);
        mode_in = m;
        mode_wr = 1'b1;
        tick();
        mode_wr = 1'b0;
        tb_mode = m;
        for (int i = 0; i < 20 && mode_busy; i++)
            tick();
        check("switch_done", mode_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd0, 8'h10, 8'h00, 1'b0};
        vecs[1] = '{3'd1, 8'h10, 8'h00, 1'b0};
        vecs[2] = '{3'd2, 8'h01, 8'h00, 1'b0};
        vecs[3] = '{3'd3, 8'h10, 8'h11, 1'b0};
        vecs[4] = '{3'd4, 8'h10, 8'h00, 1'b0};
        vecs[5] = '{3'd5, 8'h10, 8'h00, 1'b0};
        vecs[6] = '{3'd6, 8'h00, 8'h00, 1'b1};
        vecs[7] = '{3'd7, 8'h00, 8'h00, 1'b1};

        rst       = 1'b1;
        mode_in   = 3'd0;
        mode_wr   = 1'b0;
        in_valid  = 1'b0;
        in_bus    = 32'h1110_0100;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out12", {out1, out2}, 16'h0000);
        check("rst_out_mode", out_mode, 3'd0);
        check("rst_beat_cnt", beat_cnt, 8'd0);
        check("rst_mode_err", mode_err, 1'b0);
        check("rst_mode_busy", mode_busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Continuous stream in mode 0
        in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("stream_out", {out_valid, 7'd0, out1, out2, 5'd0, out_mode}, {8'h80, 8'h10, 8'h00, 8'h00});
            if (i == 5) check("stream_cnt5", beat_cnt, 8'd5);
            if (i == 8) check("sat_cnt8", beat_cnt3, 3'd7);
        end
        check("stream_cnt10", beat_cnt, 8'd10);
        check("sat_cnt10", beat_cnt3, 3'd7);
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 1'b0);

        // One beat under each mode, switched with the stage empty
        for (int v = 0; v < 8; v++) begin
            set_mode(vecs[v].mode);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("mode_out12", {out1, out2}, {vecs[v].e1, vecs[v].e2});
            check("mode_tag", out_mode, vecs[v].mode);
            check("mode_cnt", beat_cnt, 8'd1);
            check("mode_err", mode_err, vecs[v].err);
            tick();
        end

        // Switch 3 -> 2 while the stage is stalled; a second write is ignored
        set_mode(3'd3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        mode_in  = 3'd2;
        mode_wr  = 1'b1;
        tick();
        mode_in  = 3'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_busy_rdy", {mode_busy, in_ready}, 2'b10);
            check("stall_hold", {out_valid, 7'd0, out1, out2}, {8'h80, 8'h10, 8'h11});
            tick();
        end
        mode_wr   = 1'b0;
        out_ready = 1'b1;
        tick();
        tb_mode = 3'd2;
        check("exit_state", {out_valid, mode_busy}, 2'b00);
        check("exit_cnt", beat_cnt, 8'd0);
        tick();
        in_valid = 1'b0;
        check("after_switch", {out1, out2, 5'd0, out_mode}, {8'h01, 8'h00, 8'h02});
        check("after_switch_cnt", beat_cnt, 8'd1);
        tick();

        // Reset while draining discards the pending mode
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        mode_in  = 3'd6;
        mode_wr  = 1'b1;
        tick();
        mode_wr = 1'b0;
        check("drain_busy", mode_busy, 1'b1);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        tb_mode = 3'd0;
        check("rdrain_state", {mode_busy, out_valid, mode_err}, 3'b000);
        check("rdrain_cnt", beat_cnt, 8'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rdrain_beat", {out1, out2, 5'd0, out_mode}, {8'h10, 8'h00, 8'h00});
        tick();
        check("rdrain_no_apply", {mode_busy, mode_err}, 2'b00);

        // Write and accept in the same cycle: the beat keeps the old mode
        in_valid = 1'b1;
        mode_in  = 3'd3;
        mode_wr  = 1'b1;
        tick();
        mode_wr  = 1'b0;
        in_valid = 1'b0;
        tb_mode  = 3'd3;
        check("same_cycle_beat", {out1, out2, 5'd0, out_mode}, {8'h10, 8'h00, 8'h00});
        check("same_cycle_busy", mode_busy, 1'b1);
        tick();
        check("same_cycle_exit", {mode_busy, out_valid}, 2'b00);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("same_cycle_new", {out1, out2, 5'd0, out_mode}, {8'h10, 8'h11, 8'h03});
        tick();
        tick();
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
